// File: rtl/spi_frame_ctrl_if.sv
// Handshake and SPI-master-side signal bundle for spi_frame_ctrl.
// slave is the controller's view; master is the upstream/SPI-master side.
interface spi_frame_ctrl_if #(
   parameter int M = 15
);
   logic [M-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [M-1:0] rx_data;
   logic         rx_valid;
   logic         err;
   logic         ce;
   logic         st;
   logic [M-1:0] TX_MD;
   logic         LOAD;
   logic [M-1:0] RX_SD;

   modport master (
      output tx_data, tx_valid, LOAD, RX_SD,
      input  tx_ready, rx_data, rx_valid, err, ce, st, TX_MD
   );

   modport slave (
      input  tx_data, tx_valid, LOAD, RX_SD,
      output tx_ready, rx_data, rx_valid, err, ce, st, TX_MD
   );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Frame controller upstream of the SPI master shift stage: accepts a word,
// generates the divided bit clock ce and start strobe st, then captures RX_SD.
module spi_frame_ctrl #(
   parameter int M   = 15,
   parameter int DIV = 4
) (
   input logic             clk,
   input logic             rst,
   spi_frame_ctrl_if.slave bus
);

   localparam int DW = $clog2(DIV);
   localparam int EW = $clog2(M + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      TAIL,
      CAPT
   } state_e;

   state_e        state_q;
   logic [DW-1:0] div_q;
   logic [EW-1:0] edge_q;
   logic          load_s1_q;
   logic          load_s2_q;
   logic          ce_q;
   logic          st_q;
   logic          tx_ready_q;
   logic          rx_valid_q;
   logic          err_q;
   logic [M-1:0]  tx_md_q;
   logic [M-1:0]  rx_data_q;
   logic          div_last;

   assign div_last = (div_q == DW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_q      <= '0;
         edge_q     <= '0;
         load_s1_q  <= 1'b0;
         load_s2_q  <= 1'b0;
         ce_q       <= 1'b1;
         st_q       <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         tx_md_q    <= '0;
         rx_data_q  <= '0;
      end else begin
         load_s1_q  <= bus.LOAD;
         load_s2_q  <= load_s1_q;
         rx_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               ce_q   <= 1'b1;
               div_q  <= '0;
               edge_q <= '0;
               if (tx_ready_q && bus.tx_valid) begin
                  tx_md_q    <= bus.tx_data;
                  st_q       <= 1'b1;
                  tx_ready_q <= 1'b0;
                  state_q    <= START;
               end else begin
                  tx_ready_q <= 1'b1;
               end
            end
            START: begin
               if (div_last) begin
                  ce_q    <= 1'b0;
                  div_q   <= '0;
                  state_q <= SHIFT;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            SHIFT: begin
               if (div_last) begin
                  div_q <= '0;
                  ce_q  <= ~ce_q;
                  // st only drops on a rising ce so the master never races it
                  if (ce_q) begin
                     edge_q <= edge_q + 1'b1;
                     if (edge_q == EW'(M - 1)) state_q <= TAIL;
                  end else begin
                     st_q <= 1'b0;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            TAIL: begin
               if (div_last) begin
                  ce_q    <= 1'b1;
                  div_q   <= '0;
                  state_q <= CAPT;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            CAPT: begin
               // two cycles let LOAD settle through the synchroniser
               if (div_q == DW'(1)) begin
                  rx_valid_q <= 1'b1;
                  if (load_s2_q) rx_data_q <= bus.RX_SD;
                  else           err_q     <= 1'b1;
                  div_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.err      = err_q;
   assign bus.ce       = ce_q;
   assign bus.st       = st_q;
   assign bus.TX_MD    = tx_md_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: a DIV=4 instance with a loopback SPI
// master model, plus a DIV=2 instance for the frame-length formula.
module tb_spi_frame_ctrl;
   localparam int M = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_frame_ctrl_if #(.M(M)) a_if ();
   spi_frame_ctrl_if #(.M(M)) b_if ();

   spi_frame_ctrl #(.M(M), .DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   spi_frame_ctrl #(.M(M), .DIV(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SPI master model: loads on the ce fall that sees st, rotates MSB out to LSB in
   // (MISO looped to MOSI) on each later fall, raises LOAD after the M-th.
   logic [M-1:0] m_sh = '0;
   logic [M-1:0] m_rx = '0;
   int           m_cnt = M;
   logic         m_load = 1'b1;
   bit           tie_low = 1'b0;

   always @(negedge a_if.ce) begin
      if (a_if.st === 1'b1) begin
         m_sh   = a_if.TX_MD;
         m_cnt  = 0;
         m_load = 1'b0;
      end else if (m_cnt < M) begin
         m_sh = {m_sh[M-2:0], m_sh[M-1]};
         m_cnt++;
         if (m_cnt == M) begin
            m_rx   = m_sh;
            m_load = 1'b1;
         end
      end
   end

   assign a_if.LOAD  = m_load & ~tie_low;
   assign a_if.RX_SD = m_rx;
   assign b_if.LOAD  = 1'b1;
   assign b_if.RX_SD = 15'h4321;

   bit ce_obs [0:300];
   bit st_obs [0:300];
   int rv_cyc;
   int falls;
   int acc_wait;

   // Returns one observation after the accept edge, i.e. in cycle 1.
   task automatic start_frame(input logic [M-1:0] word, input bit hold);
      a_if.tx_data  = word;
      a_if.tx_valid = 1'b1;
      acc_wait = 0;
      while (a_if.tx_ready !== 1'b1 && acc_wait < 400) begin
         @(posedge clk); #1;
         acc_wait++;
      end
      if (acc_wait >= 400) check_eq("accept_timeout", 32'(acc_wait), 32'd0);
      @(posedge clk); #1;
      if (!hold) a_if.tx_valid = 1'b0;
   endtask

   task automatic watch_frame(input bit hold, input logic [M-1:0] nxt);
      logic ce_prev;
      ce_prev = 1'b1;
      rv_cyc  = 0;
      falls   = 0;
      for (int k = 1; k <= 300; k++) begin
         ce_obs[k] = a_if.ce;
         st_obs[k] = a_if.st;
         if (ce_prev && !a_if.ce) falls++;
         ce_prev = a_if.ce;
         if (a_if.rx_valid === 1'b1) begin
            rv_cyc = k;
            if (hold) a_if.tx_data = nxt;
            break;
         end
         @(posedge clk); #1;
      end
      if (rv_cyc == 0) check_eq("rx_valid_timeout", 32'(rv_cyc), 32'd131);
   endtask

   task automatic end_frame(input string fr, input logic [M-1:0] exp_rx, input logic exp_err);
      check_eq({fr, "/rx_valid_cycle"}, 32'(rv_cyc), 32'd131);
      check_eq({fr, "/ce_falls"}, 32'(falls), 32'd16);
      check_eq({fr, "/rx_data"}, 32'(a_if.rx_data), 32'(exp_rx));
      check_eq({fr, "/err"}, 32'(a_if.err), 32'(exp_err));
      check_eq({fr, "/tx_ready_at_rv"}, 32'(a_if.tx_ready), 32'd0);
      @(posedge clk); #1;
      check_eq({fr, "/rx_valid_pulse"}, 32'(a_if.rx_valid), 32'd0);
      check_eq({fr, "/tx_ready_after"}, 32'(a_if.tx_ready), 32'd1);
      check_eq({fr, "/ce_idle"}, 32'(a_if.ce), 32'd1);
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rv_seen;
      int b_rv;
      int b_falls;
      logic b_prev;

      a_if.tx_data  = '0;
      a_if.tx_valid = 1'b0;
      b_if.tx_data  = '0;
      b_if.tx_valid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst/tx_ready", 32'(a_if.tx_ready), 32'd0);
      check_eq("rst/ce", 32'(a_if.ce), 32'd1);
      check_eq("rst/st", 32'(a_if.st), 32'd0);
      check_eq("rst/rx_valid", 32'(a_if.rx_valid), 32'd0);
      check_eq("rst/err", 32'(a_if.err), 32'd0);
      check_eq("rst/rx_data", 32'(a_if.rx_data), 32'd0);
      check_eq("rst/TX_MD", 32'(a_if.TX_MD), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst/tx_ready", 32'(a_if.tx_ready), 32'd1);

      // Frame 2AB5: full edge timing (falls at 5,13..125, ce high from 129)
      start_frame(15'h2AB5, 1'b0);
      watch_frame(1'b0, '0);
      check_eq("f1/st_c1", 32'(st_obs[1]), 32'd1);
      check_eq("f1/ce_c4", 32'(ce_obs[4]), 32'd1);
      check_eq("f1/ce_c5", 32'(ce_obs[5]), 32'd0);
      check_eq("f1/st_c4", 32'(st_obs[4]), 32'd1);
      check_eq("f1/st_c5", 32'(st_obs[5]), 32'd1);
      check_eq("f1/ce_c12", 32'(ce_obs[12]), 32'd1);
      check_eq("f1/st_c12", 32'(st_obs[12]), 32'd0);
      check_eq("f1/ce_c13", 32'(ce_obs[13]), 32'd0);
      check_eq("f1/ce_c124", 32'(ce_obs[124]), 32'd1);
      check_eq("f1/ce_c125", 32'(ce_obs[125]), 32'd0);
      check_eq("f1/ce_c128", 32'(ce_obs[128]), 32'd0);
      check_eq("f1/ce_c129", 32'(ce_obs[129]), 32'd1);
      check_eq("f1/TX_MD", 32'(a_if.TX_MD), 32'h2AB5);
      end_frame("f1", 15'h2AB5, 1'b0);

      // Back-to-back with tx_valid held: second word accepted on first ready cycle
      start_frame(15'h7FFF, 1'b1);
      watch_frame(1'b1, 15'h0001);
      end_frame("b2b0", 15'h7FFF, 1'b0);
      start_frame(15'h0001, 1'b0);
      check_eq("b2b/accept_wait", 32'(acc_wait), 32'd0);
      watch_frame(1'b0, '0);
      end_frame("b2b1", 15'h0001, 1'b0);

      // Reset in cycle 40 of a frame
      start_frame(15'h5555, 1'b0);
      repeat (39) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("mid_rst/ce_c41", 32'(a_if.ce), 32'd1);
      check_eq("mid_rst/st_c41", 32'(a_if.st), 32'd0);
      @(posedge clk); #1;
      check_eq("mid_rst/ce_c42", 32'(a_if.ce), 32'd1);
      check_eq("mid_rst/st_c42", 32'(a_if.st), 32'd0);
      check_eq("mid_rst/tx_ready_c42", 32'(a_if.tx_ready), 32'd1);
      rv_seen = 0;
      repeat (150) begin
         @(posedge clk); #1;
         if (a_if.rx_valid === 1'b1) rv_seen++;
      end
      check_eq("mid_rst/no_rx_valid", 32'(rv_seen), 32'd0);
      start_frame(15'h1234, 1'b0);
      watch_frame(1'b0, '0);
      end_frame("after_rst", 15'h1234, 1'b0);

      // LOAD held low: err set, rx_data keeps the previous word
      tie_low = 1'b1;
      start_frame(15'h0F0F, 1'b0);
      watch_frame(1'b0, '0);
      end_frame("load_low", 15'h1234, 1'b1);
      tie_low = 1'b0;
      start_frame(15'h0A0A, 1'b0);
      watch_frame(1'b0, '0);
      end_frame("err_sticky", 15'h0A0A, 1'b1);

      // DIV=2: rx_valid at 1+DIV+2*DIV*M + DIV + 2 = 67
      b_if.tx_data  = 15'h6C6C;
      b_if.tx_valid = 1'b1;
      acc_wait = 0;
      while (b_if.tx_ready !== 1'b1 && acc_wait < 400) begin
         @(posedge clk); #1;
         acc_wait++;
      end
      check_eq("div2/accept_wait", 32'(acc_wait), 32'd0);
      @(posedge clk); #1;
      b_if.tx_valid = 1'b0;
      b_rv    = 0;
      b_falls = 0;
      b_prev  = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         if (b_prev && !b_if.ce) b_falls++;
         b_prev = b_if.ce;
         if (b_if.rx_valid === 1'b1) begin
            b_rv = k;
            break;
         end
         @(posedge clk); #1;
      end
      check_eq("div2/rx_valid_cycle", 32'(b_rv), 32'd67);
      check_eq("div2/ce_falls", 32'(b_falls), 32'd16);
      check_eq("div2/rx_data", 32'(b_if.rx_data), 32'h4321);
      check_eq("div2/err", 32'(b_if.err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
